// File: rtl/frame_loader_pkg.sv
// frame_loader_pkg: shared defaults and types for the frame loader.
//   IMG_W, IMG_H, PIX_W : default raster geometry and pixel width
//   FRAME_SIZE          : pixels per frame
//   ADDR_W              : width of a pixel index within a frame
//   state_e             : loader FSM state
package frame_loader_pkg;

  localparam int unsigned IMG_W      = 320;
  localparam int unsigned IMG_H      = 240;
  localparam int unsigned PIX_W      = 8;
  localparam int unsigned FRAME_SIZE = IMG_W * IMG_H;
  localparam int unsigned ADDR_W     = $clog2(FRAME_SIZE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_e;

endpackage

// File: rtl/frame_addr_counter.sv
// frame_addr_counter: write-address counter for the frame array.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : force address to 0 (highest priority)
//   load_one  : force address to 1 (frame restart after the SOF pixel)
//   incr      : advance address by one
//   addr      : current write address
//   last      : address points at the final pixel of the frame
module frame_addr_counter #(
  parameter int unsigned NUM_PIX = frame_loader_pkg::FRAME_SIZE,
  parameter int unsigned AW      = $clog2(NUM_PIX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load_one,
  input  logic          incr,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic [AW-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (clear) begin
      addr_d = '0;
    end else if (load_one) begin
      addr_d = AW'(1);
    end else if (incr) begin
      addr_d = addr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;
  assign last = (addr_q == AW'(NUM_PIX - 1));

endmodule

// File: rtl/frame_loader.sv
// frame_loader: assembles a raster-order pixel stream into a full frame and
// holds it stable until the consumer acknowledges it.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   s_valid/s_ready/s_data/s_sof : pixel input stream, s_sof marks pixel (0,0)
//   frame        : assembled frame, index = row*IMG_W + col
//   frame_valid  : frame complete and frozen
//   frame_ack    : consumer has taken the frame (only honoured while full)
//   frame_count  : completed-and-acknowledged frames, wraps at 16 bits
//   err_sof      : one-cycle pulse on a SOF beat received mid-frame
// Configuration macro: FRAME_LOADER_SOF_RESYNC_EN
//   defined   - a SOF beat mid-frame restarts the frame and pulses err_sof
//   undefined - s_sof is ignored mid-frame; err_sof is tied low
module frame_loader #(
  parameter int unsigned IMG_W = frame_loader_pkg::IMG_W,
  parameter int unsigned IMG_H = frame_loader_pkg::IMG_H,
  parameter int unsigned PIX_W = frame_loader_pkg::PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_sof,
  output logic [PIX_W-1:0] frame [IMG_W*IMG_H],
  output logic             frame_valid,
  input  logic             frame_ack,
  output logic [15:0]      frame_count,
  output logic             err_sof
);

  import frame_loader_pkg::*;

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned AW   = $clog2(NPIX);

  state_e        state_q, state_d;
  logic          accept;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] addr;
  logic          last;
  logic          cnt_clear, cnt_load, cnt_incr;
  logic          count_inc;
`ifdef FRAME_LOADER_SOF_RESYNC_EN
  logic          err_d, err_q;
`endif

  // Handshake outputs come from registered state only.
  assign s_ready     = (state_q == IDLE) || (state_q == FILL);
  assign frame_valid = (state_q == FULL);
  assign accept      = s_valid && s_ready;

  frame_addr_counter #(
    .NUM_PIX (NPIX),
    .AW      (AW)
  ) u_addr (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .load_one (cnt_load),
    .incr     (cnt_incr),
    .addr     (addr),
    .last     (last)
  );

  always_comb begin
    state_d   = state_q;
    wr_en     = 1'b0;
    wr_idx    = addr;
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_incr  = 1'b0;
    count_inc = 1'b0;
`ifdef FRAME_LOADER_SOF_RESYNC_EN
    err_d     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // Non-SOF beats are consumed and dropped while waiting for a frame start.
        if (accept && s_sof) begin
          wr_en    = 1'b1;
          wr_idx   = '0;
          cnt_load = 1'b1;
          state_d  = FILL;
        end
      end
      FILL: begin
        if (accept) begin
`ifdef FRAME_LOADER_SOF_RESYNC_EN
          if (s_sof) begin
            wr_en    = 1'b1;
            wr_idx   = '0;
            cnt_load = 1'b1;
            err_d    = 1'b1;
          end else
`endif
          begin
            wr_en = 1'b1;
            if (last) begin
              cnt_clear = 1'b1;
              state_d   = FULL;
            end else begin
              cnt_incr = 1'b1;
            end
          end
        end
      end
      FULL: begin
        if (frame_ack) begin
          count_inc = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      frame_count <= '0;
    end else begin
      state_q <= state_d;
      if (count_inc) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // Unwritten entries keep their previous contents across frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NPIX); i++) begin
        frame[i] <= '0;
      end
    end else if (wr_en) begin
      frame[wr_idx] <= s_data;
    end
  end

`ifdef FRAME_LOADER_SOF_RESYNC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err_sof = err_q;
`else
  assign err_sof = 1'b0;
`endif

endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader: randomized and directed checks of frame_loader against a
// behavioural frame model. Uses a reduced 16x12 raster to keep runs short.
module tb_frame_loader;

  localparam int unsigned W    = 16;
  localparam int unsigned H    = 12;
  localparam int unsigned NPIX = W * H;
  localparam logic [7:0]  LAST_EXP = 8'((NPIX - 1) % 256);

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_sof;
  logic [7:0] frame [NPIX];
  logic       frame_valid;
  logic       frame_ack;
  logic [15:0] frame_count;
  logic       err_sof;

  always #5 clk = ~clk;

  frame_loader #(
    .IMG_W (W),
    .IMG_H (H),
    .PIX_W (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_sof       (s_sof),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .frame_count (frame_count),
    .err_sof     (err_sof)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input longint unsigned got,
                          input longint unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: the frame being built, where the next pixel goes, and
  // whether a complete frame is waiting for its ack.
  logic [7:0]  m_frame [NPIX];
  bit          m_fill, m_full, m_err;
  int          m_idx;
  int unsigned m_count;
`ifdef FRAME_LOADER_SOF_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  function automatic void model_reset();
    for (int i = 0; i < int'(NPIX); i++) m_frame[i] = 8'h00;
    m_fill  = 0;
    m_full  = 0;
    m_err   = 0;
    m_idx   = 0;
    m_count = 0;
  endfunction

  function automatic void model_step(input bit v, input logic [7:0] d, input bit sof,
                                     input bit ack);
    m_err = 0;
    if (m_full) begin
      if (ack) begin
        m_full  = 0;
        m_count = (m_count + 1) % 65536;
      end
    end else if (v) begin
      if (!m_fill) begin
        if (sof) begin
          m_frame[0] = d;
          m_idx      = 1;
          m_fill     = 1;
        end
      end else if (RESYNC && sof) begin
        m_frame[0] = d;
        m_idx      = 1;
        m_err      = 1;
      end else begin
        m_frame[m_idx] = d;
        m_idx++;
        if (m_idx == int'(NPIX)) begin
          m_idx  = 0;
          m_fill = 0;
          m_full = 1;
        end
      end
    end
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, ".s_ready"}, s_ready, !m_full);
    check_eq({tag, ".frame_valid"}, frame_valid, m_full);
    check_eq({tag, ".frame_count"}, frame_count, m_count);
    check_eq({tag, ".err_sof"}, err_sof, m_err);
  endtask

  task automatic compare_frame(input string tag);
    int bad = 0;
    for (int i = 0; i < int'(NPIX); i++) begin
      if (frame[i] !== m_frame[i]) bad++;
    end
    check_eq({tag, ".bad_pixels"}, bad, 0);
  endtask

  // Drive one cycle of stimulus, advance the model at the edge, check #1 later.
  task automatic cycle(input bit v, input logic [7:0] d, input bit sof, input bit ack);
    s_valid   = v;
    s_data    = d;
    s_sof     = sof;
    frame_ack = ack;
    @(posedge clk);
    model_step(v, d, sof, ack);
    #1;
    check_outputs("cyc");
  endtask

  task automatic do_reset();
    s_valid   = 0;
    s_data    = 0;
    s_sof     = 0;
    frame_ack = 0;
    rst       = 1;
    #2;
    model_reset();
    check_outputs("in_rst");
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    check_outputs("post_rst");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int beats;
    bit prev_full;
    bit v, sof, ack;

    // Reset state
    do_reset();
    check_eq("rst.s_ready", s_ready, 1);
    check_eq("rst.frame_valid", frame_valid, 0);
    check_eq("rst.frame_count", frame_count, 0);
    check_eq("rst.err_sof", err_sof, 0);
    check_eq("rst.frame0", frame[0], 8'h00);
    check_eq("rst.frame_last", frame[NPIX-1], 8'h00);

    // Full frame, data = i % 256
    for (int i = 0; i < int'(NPIX); i++) begin
      if (i == int'(NPIX) - 1) check_eq("seq.valid_before_last", frame_valid, 0);
      cycle(1, 8'(i % 256), i == 0, 0);
    end
    check_eq("seq.valid_on_last", frame_valid, 1);
    check_eq("seq.s_ready", s_ready, 0);
    check_eq("seq.frame130", frame[130], 8'h82);
    check_eq("seq.frame_last", frame[NPIX-1], LAST_EXP);
    compare_frame("seq");

    // Hold off upstream while full; nothing may be consumed
    repeat (5) cycle(1, 8'h33, 0, 0);
    check_eq("hold.frame_valid", frame_valid, 1);
    check_eq("hold.frame0", frame[0], 8'h00);
    compare_frame("hold");
    cycle(0, 8'h00, 0, 1);
    check_eq("ack.frame_valid", frame_valid, 0);
    check_eq("ack.s_ready", s_ready, 1);
    check_eq("ack.frame_count", frame_count, 1);

    // Beats before SOF are discarded
    repeat (10) cycle(1, 8'hAA, 0, 0);
    check_eq("discard.frame0", frame[0], 8'h00);
    cycle(1, 8'h11, 1, 0);
    for (int b = 0; b < 4 * int'(NPIX) && !m_full; b++) cycle(1, 8'($urandom), 0, 0);
    check_eq("sof11.frame_valid", frame_valid, 1);
    check_eq("sof11.frame0", frame[0], 8'h11);
    compare_frame("sof11");
    cycle(0, 8'h00, 0, 1);

    // SOF at beat 100
    beats = 0;
    for (int b = 0; b < 4 * int'(NPIX) && !m_full; b++) begin
      cycle(1, (b == 100) ? 8'h55 : 8'($urandom), (b == 0) || (b == 100), 0);
      beats++;
      if (b == 100) begin
`ifdef FRAME_LOADER_SOF_RESYNC_EN
        check_eq("midsof.err_sof", err_sof, 1);
`else
        check_eq("midsof.err_sof", err_sof, 0);
`endif
      end
    end
    check_eq("midsof.frame_valid", frame_valid, 1);
`ifdef FRAME_LOADER_SOF_RESYNC_EN
    check_eq("midsof.beats", beats, 100 + NPIX);
    check_eq("midsof.frame0", frame[0], 8'h55);
`else
    check_eq("midsof.beats", beats, NPIX);
    check_eq("midsof.frame100", frame[100], 8'h55);
`endif
    compare_frame("midsof");
    cycle(0, 8'h00, 0, 1);

    // Randomized traffic
    prev_full = m_full;
    for (int c = 0; c < 3000; c++) begin
      v   = ($urandom_range(0, 9) < 7);
      sof = m_fill ? ($urandom_range(0, 499) == 0) : ($urandom_range(0, 3) == 0);
      ack = ($urandom_range(0, 3) == 0);
      cycle(v, 8'($urandom), sof, ack);
      if (m_full && !prev_full) compare_frame("rand");
      prev_full = m_full;
    end
    compare_frame("rand_end");

    // Reset in the middle of a fill
    if (m_full) cycle(0, 8'h00, 0, 1);
    cycle(1, 8'h01, 1, 0);
    for (int b = 1; b < 50; b++) cycle(1, 8'hC3, 0, 0);
    do_reset();
    check_eq("midrst.s_ready", s_ready, 1);
    check_eq("midrst.frame_valid", frame_valid, 0);
    check_eq("midrst.frame_count", frame_count, 0);
    check_eq("midrst.frame49", frame[49], 8'h00);
    compare_frame("midrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_loader.md
# frame_loader

Upstream ingest stage for the image-processing datapath. Accepts a serial 8-bit grayscale pixel stream with a valid/ready handshake and start-of-frame marker. Assembles a full 320×240 raster-order frame in a register array and presents it as an unpacked frame port to the processing block. Holds the frame stable until the consumer acknowledges it.

## Interface
- IMG_W, 320, pixels per row
- IMG_H, 240, rows per frame
- PIX_W, 8, bits per pixel
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  input pixel beat valid
- s_ready  out  1  loader can accept a beat
- s_data  in  PIX_W  pixel value
- s_sof  in  1  beat is pixel (0,0) of a frame
- frame  out  PIX_W × IMG_W*IMG_H unpacked  assembled frame, index = row*IMG_W+col
- frame_valid  out  1  frame complete and stable
- frame_ack  in  1  consumer has taken the frame
- frame_count  out  16  completed-and-acknowledged frames
- err_sof  out  1  one-cycle pulse: SOF mid-frame (see Configuration)

## Operation
- Beat accepted on posedge when s_valid && s_ready.
- States: IDLE, FILL, FULL.
- IDLE: s_ready=1. Beats with s_sof=0 accepted and discarded. Beat with s_sof=1 written to frame[0]; addr←1; → FILL.
- FILL: s_ready=1. Each accepted beat writes frame[addr]; addr++. Beat written at addr==IMG_W*IMG_H-1 → FULL, addr←0.
- FULL: s_ready=0, frame_valid=1, frame contents frozen. frame_ack=1 → IDLE, frame_count+1.
- frame_ack outside FULL is ignored.
- addr width $clog2(IMG_W*IMG_H) (17 bits at defaults). frame_count wraps 0xFFFF→0x0000.
- frame entries not written in the current frame keep their previous value.
- Reset values: state IDLE, addr 0, all frame entries 0, frame_valid 0, frame_count 0, err_sof 0. s_ready=1 (derived from IDLE).
- Reset mid-FILL or mid-FULL: partial or pending frame discarded; all outputs take their reset values.

## Timing
- s_ready and frame_valid are decoded from the registered state only. They have no combinational path from s_valid or frame_ack.
- frame_valid rises on the same edge that writes the last pixel. Minimum fill is IMG_W*IMG_H accepted beats, starting at the SOF beat.
- frame_ack sampled high in FULL: the next cycle shows frame_valid=0, s_ready=1, and frame_count incremented.
- Throughput: one pixel per cycle in FILL. There is one lost cycle per frame at minimum: the FULL cycle spent waiting for ack.
- s_valid held high in FULL: no beat is consumed. The upstream source must hold its data.

## Configuration
- FRAME_LOADER_SOF_RESYNC_EN defined:
  - A beat with s_sof=1 accepted in FILL pulses err_sof high for exactly one cycle.
  - That beat is written to frame[0] and addr←1, restarting the frame.
- FRAME_LOADER_SOF_RESYNC_EN undefined:
  - s_sof is ignored in FILL; the beat is stored as an ordinary pixel.
  - err_sof is tied to 0.

## Structure
- Package frame_loader_pkg holds:
  - defaults IMG_W, IMG_H, PIX_W
  - FRAME_SIZE = IMG_W*IMG_H
  - ADDR_W = $clog2(FRAME_SIZE)
  - state enum (IDLE, FILL, FULL)
- One sub-module, frame_addr_counter:
  - load-to-1, increment and clear controls
  - last-pixel flag output (addr==FRAME_SIZE-1)
- Top level holds the FSM, frame array, frame_count and err_sof.

## Test plan
- Reset → s_ready=1, frame_valid=0, frame_count=0, err_sof=0, frame[0]=frame[76799]=0x00.
- Stream 76800 beats, data=i%256, s_sof on i=0 → frame_valid high on the edge accepting i=76799; frame[130]=0x82; frame[76799]=0xFF; s_ready=0.
- 10 beats of 0xAA with s_sof=0, then a frame starting with SOF data 0x11 → frame[0]=0x11; no 0xAA stored at index 0..9 unless streamed after SOF.
- In FULL, hold s_valid=1 and frame_ack=0 for 5 cycles → no beat consumed and frame unchanged. Then a 1-cycle frame_ack → next cycle frame_valid=0, s_ready=1, frame_count=1.
- SOF at beat 100 (data 0x55):
  - with FRAME_LOADER_SOF_RESYNC_EN: err_sof high for 1 cycle, frame[0]=0x55, frame_valid after 76800 further beats counted from that SOF.
  - without the macro: err_sof=0, frame[100]=0x55, frame_valid after 76800 total beats.
- Assert rst at beat 5000 of FILL → next cycle IDLE, s_ready=1, frame[4999]=0x00, frame_count=0, frame_valid=0.
